// File: rtl/dac_sweep_sequencer_if.sv
// Control/data bundle between the UART command layer and the sweep sequencer.
// The master drives profile writes and run control; the slave returns DAC settings and status.
interface dac_sweep_sequencer_if #(
    parameter int NUM_PROFILES = 4,
    parameter int DWELL_WIDTH  = 24
);
    localparam int IDXW = $clog2(NUM_PROFILES);

    logic                   ipWrEn;
    logic [IDXW+1:0]        ipWrAddr;
    logic [7:0]             ipWrData;
    logic                   ipStart;
    logic                   ipStop;
    logic                   ipLoop;
    logic [IDXW-1:0]        ipLast;
    logic [DWELL_WIDTH-1:0] ipDwell;
    logic [1:0]             opControl;
    logic [7:0]             opStartFreq;
    logic [7:0]             opEndFreq;
    logic [7:0]             opStep;
    logic [IDXW-1:0]        opProfile;
    logic                   opBusy;
    logic                   opDone;
    logic                   opWrErr;

    modport master (
        output ipWrEn, ipWrAddr, ipWrData, ipStart, ipStop, ipLoop, ipLast, ipDwell,
        input  opControl, opStartFreq, opEndFreq, opStep, opProfile, opBusy, opDone, opWrErr
    );

    modport slave (
        input  ipWrEn, ipWrAddr, ipWrData, ipStart, ipStop, ipLoop, ipLast, ipDwell,
        output opControl, opStartFreq, opEndFreq, opStep, opProfile, opBusy, opDone, opWrErr
    );
endinterface

// File: rtl/dac_sweep_sequencer.sv
// Plays back stored sweep profiles to the DAC, one dwell period each, with a
// one-cycle stop gap (SETUP) before every profile so the DAC restarts cleanly.
module dac_sweep_sequencer #(
    parameter int NUM_PROFILES = 4,
    parameter int DWELL_WIDTH  = 24
) (
    input logic                   ipClk,
    input logic                   ipnReset,
    dac_sweep_sequencer_if.slave  bus
);
    localparam int IDXW = $clog2(NUM_PROFILES);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [IDXW-1:0]        last_q, last_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]             mode_q  [NUM_PROFILES];
    logic [7:0]             mode_d  [NUM_PROFILES];
    logic [7:0]             start_q [NUM_PROFILES];
    logic [7:0]             start_d [NUM_PROFILES];
    logic [7:0]             end_q   [NUM_PROFILES];
    logic [7:0]             end_d   [NUM_PROFILES];
    logic [7:0]             step_q  [NUM_PROFILES];
    logic [7:0]             step_d  [NUM_PROFILES];
    logic [7:0]             sf_q, sf_d, ef_q, ef_d, st_q, st_d;
    logic                   wr_err_q, wr_err_d;

    logic [IDXW-1:0]        wr_idx;
    logic [1:0]             wr_fld;
    logic                   wr_hit;
    logic [1:0]             cur_ctl;
    state_e                 adv_state;
    logic [IDXW-1:0]        adv_idx;

    function automatic logic [1:0] decode(input logic [7:0] m);
        case (m)
            8'h00:   return 2'b01;
            8'hFE:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    assign wr_idx  = bus.ipWrAddr[IDXW+1:2];
    assign wr_fld  = bus.ipWrAddr[1:0];
    // The active profile's bytes are frozen while it is being set up or played.
    assign wr_hit  = ((state_q == SETUP) || (state_q == RUN)) && (wr_idx == idx_q);
    assign cur_ctl = decode(mode_q[idx_q]);

    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            last_q   <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            sf_q     <= '0;
            ef_q     <= '0;
            st_q     <= '0;
            wr_err_q <= 1'b0;
            for (int i = 0; i < NUM_PROFILES; i++) begin
                mode_q[i]  <= 8'hFD;
                start_q[i] <= '0;
                end_q[i]   <= '0;
                step_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            sf_q     <= sf_d;
            ef_q     <= ef_d;
            st_q     <= st_d;
            wr_err_q <= wr_err_d;
            mode_q   <= mode_d;
            start_q  <= start_d;
            end_q    <= end_d;
            step_q   <= step_d;
        end
    end

    // Where the sequence goes once the current profile is finished or skipped.
    always_comb begin
        adv_state = DONE;
        adv_idx   = idx_q;
        if (idx_q < last_q) begin
            adv_state = SETUP;
            adv_idx   = idx_q + 1'b1;
        end else if (bus.ipLoop) begin
            adv_state = SETUP;
            adv_idx   = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        sf_d     = sf_q;
        ef_d     = ef_q;
        st_d     = st_q;
        wr_err_d = 1'b0;
        mode_d   = mode_q;
        start_d  = start_q;
        end_d    = end_q;
        step_d   = step_q;

        case (state_q)
            IDLE: begin
                if (bus.ipStart) begin
                    state_d = SETUP;
                    idx_d   = '0;
                    last_d  = bus.ipLast;
                    dwell_d = bus.ipDwell;
                end
            end
            SETUP: begin
                sf_d = start_q[idx_q];
                ef_d = end_q[idx_q];
                st_d = step_q[idx_q];
                if (cur_ctl != 2'b00) begin
                    state_d = RUN;
                    cnt_d   = (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;
                end else begin
                    state_d = adv_state;
                    idx_d   = adv_idx;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == DWELL_WIDTH'(1)) begin
                    state_d = adv_state;
                    idx_d   = adv_idx;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.ipStop) state_d = IDLE;

        if (bus.ipWrEn) begin
            if (wr_hit) begin
                wr_err_d = 1'b1;
            end else begin
                case (wr_fld)
                    2'd0:    mode_d[wr_idx]  = bus.ipWrData;
                    2'd1:    start_d[wr_idx] = bus.ipWrData;
                    2'd2:    end_d[wr_idx]   = bus.ipWrData;
                    default: step_d[wr_idx]  = bus.ipWrData;
                endcase
            end
        end
    end

    // In SETUP the DAC sees the new profile's bytes straight from storage; afterwards the held copy.
    always_comb begin
        bus.opControl   = (state_q == RUN) ? cur_ctl : 2'b00;
        bus.opStartFreq = (state_q == SETUP) ? start_q[idx_q] : sf_q;
        bus.opEndFreq   = (state_q == SETUP) ? end_q[idx_q]   : ef_q;
        bus.opStep      = (state_q == SETUP) ? step_q[idx_q]  : st_q;
        bus.opProfile   = idx_q;
        bus.opBusy      = (state_q != IDLE);
        bus.opDone      = (state_q == DONE);
        bus.opWrErr     = wr_err_q;
    end
endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// Bench for dac_sweep_sequencer: directed vector tables, hand sequences for
// write rejection and reset, and random profile runs against a playback model.
module tb_dac_sweep_sequencer;
    localparam int NP = 4;
    localparam int DW = 24;
    localparam int IW = 2;

    typedef struct {
        logic       start, stop, loop;
        logic [1:0] ctl;
        logic [1:0] prof;
        logic [7:0] sf, ef, st;
        logic       busy, done, chk_f;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dac_sweep_sequencer_if #(.NUM_PROFILES(NP), .DWELL_WIDTH(DW)) bus();
    dac_sweep_sequencer #(.NUM_PROFILES(NP), .DWELL_WIDTH(DW)) dut (
        .ipClk(clk), .ipnReset(rst_n), .bus(bus)
    );

    int n_pass = 0;
    int n_tot  = 0;
    logic [7:0] m_mode [NP];
    logic [7:0] m_sf   [NP];
    logic [7:0] m_ef   [NP];
    logic [7:0] m_st   [NP];
    vec_t tbl [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(input logic start, stop, loop, input logic [1:0] ctl, prof,
                               input logic [7:0] sf, ef, st, input logic busy, done, chk_f);
        vec_t r;
        r.start = start; r.stop = stop; r.loop = loop; r.ctl = ctl; r.prof = prof;
        r.sf = sf; r.ef = ef; r.st = st; r.busy = busy; r.done = done; r.chk_f = chk_f;
        return r;
    endfunction

    function automatic logic [1:0] mdec(input logic [7:0] m);
        if (m == 8'h00) return 2'b01;
        if (m == 8'hFE) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_mode[i] = 8'hFD; m_sf[i] = 8'h00; m_ef[i] = 8'h00; m_st[i] = 8'h00;
        end
    endtask

    task automatic check_vec(input string tag, input vec_t e);
        chk({tag, ".ctl"}, 32'(bus.opControl), 32'(e.ctl));
        chk({tag, ".busy"}, 32'(bus.opBusy), 32'(e.busy));
        chk({tag, ".done"}, 32'(bus.opDone), 32'(e.done));
        if (e.chk_f) begin
            chk({tag, ".prof"}, 32'(bus.opProfile), 32'(e.prof));
            chk({tag, ".freq"}, {8'h0, bus.opStartFreq, bus.opEndFreq, bus.opStep},
                {8'h0, e.sf, e.ef, e.st});
        end
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            bus.ipStart = tbl[i].start;
            bus.ipStop  = tbl[i].stop;
            bus.ipLoop  = tbl[i].loop;
            tick();
            bus.ipStart = 1'b0;
            bus.ipStop  = 1'b0;
            check_vec($sformatf("%s[%0d]", tag, i), tbl[i]);
        end
        bus.ipLoop = 1'b0;
    endtask

    task automatic wr(input int p, input int f, input logic [7:0] d, input bit ok);
        bus.ipWrEn   = 1'b1;
        bus.ipWrAddr = {p[IW-1:0], f[1:0]};
        bus.ipWrData = d;
        tick();
        bus.ipWrEn = 1'b0;
        chk("wr_err", 32'(bus.opWrErr), ok ? 32'd0 : 32'd1);
        if (ok) begin
            case (f)
                0: m_mode[p] = d;
                1: m_sf[p]   = d;
                2: m_ef[p]   = d;
                default: m_st[p] = d;
            endcase
        end
    endtask

    // Expected playback derived from the stored profiles: a gap cycle per
    // profile, max(dwell,1) active cycles for each valid one, then one done cycle.
    task automatic model_run(input string tag, input int last, input int dwell);
        vec_t q [$];
        int   n;
        n = (dwell == 0) ? 1 : dwell;
        for (int p = 0; p <= last; p++) begin
            q.push_back(v(0, 0, 0, 2'b00, p[1:0], m_sf[p], m_ef[p], m_st[p], 1, 0, 1));
            if (mdec(m_mode[p]) != 2'b00)
                for (int k = 0; k < n; k++)
                    q.push_back(v(0, 0, 0, mdec(m_mode[p]), p[1:0], m_sf[p], m_ef[p], m_st[p], 1, 0, 1));
        end
        q.push_back(v(0, 0, 0, 2'b00, last[1:0], m_sf[last], m_ef[last], m_st[last], 1, 1, 1));
        q.push_back(v(0, 0, 0, 2'b00, 2'b00, 8'h0, 8'h0, 8'h0, 0, 0, 0));
        bus.ipLast  = last[IW-1:0];
        bus.ipDwell = DW'(dwell);
        bus.ipLoop  = 1'b0;
        foreach (q[i]) begin
            bus.ipStart = (i == 0);
            tick();
            bus.ipStart = 1'b0;
            if (i == 0) begin
                bus.ipLast  = IW'($urandom);
                bus.ipDwell = DW'($urandom_range(0, 200));
            end
            check_vec($sformatf("%s[%0d]", tag, i), q[i]);
        end
    endtask

    initial begin
        int last, dwell;
        bus.ipWrEn = 0; bus.ipWrAddr = '0; bus.ipWrData = '0; bus.ipStart = 0;
        bus.ipStop = 0; bus.ipLoop = 0; bus.ipLast = '0; bus.ipDwell = '0;
        model_reset();
        #2;
        chk("in_reset", {bus.opControl, bus.opBusy, bus.opDone, bus.opProfile,
                         bus.opStartFreq, bus.opEndFreq, bus.opStep, bus.opWrErr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("reset_idle", {bus.opControl, bus.opBusy, bus.opDone, bus.opProfile,
                               bus.opStartFreq, bus.opEndFreq, bus.opStep, bus.opWrErr}, 32'd0);
        end

        // Two-profile run, no loop, dwell 5; a start pulse mid-run must be ignored.
        wr(0, 0, 8'h00, 1); wr(0, 1, 8'h10, 1); wr(0, 2, 8'h50, 1); wr(0, 3, 8'h02, 1);
        wr(1, 0, 8'hFE, 1); wr(1, 1, 8'h20, 1); wr(1, 2, 8'h80, 1); wr(1, 3, 8'h04, 1);
        bus.ipLast = 2'd1; bus.ipDwell = 24'd5;
        tbl.delete();
        tbl.push_back(v(1, 0, 0, 2'b00, 0, 8'h10, 8'h50, 8'h02, 1, 0, 1));
        for (int i = 0; i < 5; i++) tbl.push_back(v(i == 2, 0, 0, 2'b01, 0, 8'h10, 8'h50, 8'h02, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 2'b00, 1, 8'h20, 8'h80, 8'h04, 1, 0, 1));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0, 0, 0, 2'b11, 1, 8'h20, 8'h80, 8'h04, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 2'b00, 1, 8'h20, 8'h80, 8'h04, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 2'b00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        run_table("basic");

        // Looping with dwell 0, then stop (together with start) mid-RUN.
        bus.ipDwell = 24'd0;
        tbl.delete();
        tbl.push_back(v(1, 0, 1, 2'b00, 0, 8'h10, 8'h50, 8'h02, 1, 0, 1));
        for (int k = 0; k < 2; k++) begin
            if (k > 0) tbl.push_back(v(0, 0, 1, 2'b00, 0, 8'h10, 8'h50, 8'h02, 1, 0, 1));
            tbl.push_back(v(0, 0, 1, 2'b01, 0, 8'h10, 8'h50, 8'h02, 1, 0, 1));
            tbl.push_back(v(0, 0, 1, 2'b00, 1, 8'h20, 8'h80, 8'h04, 1, 0, 1));
            tbl.push_back(v(0, 0, 1, 2'b11, 1, 8'h20, 8'h80, 8'h04, 1, 0, 1));
        end
        tbl.push_back(v(1, 1, 1, 2'b00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 2'b00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        run_table("loop");

        // Invalid middle profile is skipped after its gap cycle.
        wr(1, 0, 8'hFD, 1);
        wr(2, 0, 8'h00, 1); wr(2, 1, 8'h30, 1); wr(2, 2, 8'h60, 1); wr(2, 3, 8'h06, 1);
        model_run("skip", 2, 3);

        // Write to the playing profile is rejected; a write ahead of playback lands.
        wr(1, 0, 8'hFE, 1);
        bus.ipLast = 2'd1; bus.ipDwell = 24'd5; bus.ipLoop = 1'b0;
        bus.ipStart = 1'b1; tick(); bus.ipStart = 1'b0;
        tick();
        chk("p0_running", 32'(bus.opControl), 32'd1);
        wr(0, 3, 8'h77, 0);
        chk("p0_step_held", 32'(bus.opStep), 32'h02);
        wr(1, 1, 8'h99, 1);
        for (int i = 0; i < 20 && bus.opProfile != 2'd1; i++) tick();
        chk("reach_p1", 32'(bus.opProfile), 32'd1);
        chk("p1_new_start", 32'(bus.opStartFreq), 32'h99);
        for (int i = 0; i < 30 && bus.opBusy; i++) tick();
        chk("wr_run_ends", 32'(bus.opBusy), 32'd0);
        model_run("after_wr", 1, 2);

        // Random profile contents, lengths and dwells.
        for (int r = 0; r < 20; r++) begin
            for (int p = 0; p < NP; p++) begin
                logic [7:0] m;
                case ($urandom_range(0, 3))
                    0: m = 8'h00;
                    1: m = 8'hFE;
                    2: m = 8'hFD;
                    default: m = 8'($urandom);
                endcase
                wr(p, 0, m, 1);
                wr(p, 1, 8'($urandom), 1);
                wr(p, 2, 8'($urandom), 1);
                wr(p, 3, 8'($urandom), 1);
            end
            last  = (r == 0) ? 0 : (r == 1) ? NP - 1 : $urandom_range(0, NP - 1);
            dwell = $urandom_range(0, 4);
            model_run($sformatf("rnd%0d", r), last, dwell);
        end

        // Reset in the middle of a run clears state and profile storage.
        for (int p = 0; p < NP; p++) wr(p, 0, 8'h00, 1);
        bus.ipLast = 2'd3; bus.ipDwell = 24'd5;
        bus.ipStart = 1'b1; tick(); bus.ipStart = 1'b0;
        tick(); tick();
        chk("pre_reset_run", 32'(bus.opControl), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset", {bus.opControl, bus.opBusy, bus.opDone, bus.opProfile,
                          bus.opStartFreq, bus.opEndFreq, bus.opStep, bus.opWrErr}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.ipStart = 1'b1; bus.ipStop = 1'b1;
        tick();
        bus.ipStart = 1'b0; bus.ipStop = 1'b0;
        chk("start_stop_idle", {30'd0, bus.opBusy, bus.opDone}, 32'd0);
        chk("start_stop_ctl", 32'(bus.opControl), 32'd0);
        model_run("post_reset", 3, 2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/dac_sweep_sequencer.md
Name: dac_sweep_sequencer

Overview:
Profile sequencer that sits between the UART command layer and the DAC sweep generator. It holds NUM_PROFILES sweep profiles (mode, start, end, step), each written a byte at a time. On start it plays the profiles back in order, holding each for a programmable dwell, with a one-cycle stop gap between profiles so the DAC restarts cleanly. Its outputs drive the DAC's control, start-frequency, end-frequency and step inputs directly.

Parameters:
NUM_PROFILES, 4, number of stored profiles; power of two, 2..16.
DWELL_WIDTH, 24, width of the dwell counter in ipClk cycles.
IDXW, $clog2(NUM_PROFILES), derived profile-index width; not user-set.

Ports:
ipClk  in  1  system clock.
ipnReset  in  1  asynchronous active-low reset.
ipWrEn  in  1  profile byte write strobe, one write per cycle.
ipWrAddr  in  IDXW+2  {profile index, field}; field 0=mode, 1=start, 2=end, 3=step.
ipWrData  in  8  write data.
ipStart  in  1  start pulse; ignored while busy.
ipStop  in  1  abort pulse; highest priority.
ipLoop  in  1  sampled at end of last profile; 1 = wrap to profile 0.
ipLast  in  IDXW  index of last profile to play; latched on start.
ipDwell  in  DWELL_WIDTH  cycles per profile; latched on start; 0 treated as 1.
opControl  out  2  DAC control: 01 saw, 11 triangle, 00 stop.
opStartFreq  out  8  DAC start frequency.
opEndFreq  out  8  DAC end frequency.
opStep  out  8  DAC step.
opProfile  out  IDXW  index of current profile.
opBusy  out  1  high in every state except IDLE.
opDone  out  1  one-cycle pulse when a non-looping run finishes.
opWrErr  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; all profile mode bytes 8'hFD (off); start, end and step bytes 0; latched last and dwell 0.
- Mode decode: 8'h00 -> 01 (saw); 8'hFE -> 11 (triangle); any other value marks the profile invalid.
- States: IDLE, SETUP, RUN, DONE.
- IDLE: opControl=00. If ipStart is high at edge k, then at edge k+1: state=SETUP, index=0, ipLast and ipDwell latched.
- SETUP (exactly 1 cycle):
  - opControl=00, opProfile=index, opStartFreq/opEndFreq/opStep = that profile's bytes.
  - Valid mode: next state RUN, dwell counter loaded with max(dwell,1).
  - Invalid mode: no RUN; advance as at end of RUN.
- RUN:
  - opControl=decoded mode; frequency outputs held; counter decrements each cycle.
  - When counter==1: if index<latched last, index+1 -> SETUP.
  - Else if ipLoop=1, index=0 -> SETUP.
  - Else -> DONE.
  - Net effect: opControl is nonzero for exactly max(dwell,1) consecutive cycles per valid profile.
- DONE (1 cycle): opDone=1, opControl=00, opBusy=1; next state IDLE. Frequency outputs keep their last values.
- ipStop: from any state, next edge -> IDLE with opControl=00. Beats ipStart, loop and advance in the same cycle. ipStop does not produce opDone.
- ipStart while busy: ignored, no error flag.
- Writes:
  - Accepted in any state, except a write to the profile currently in SETUP/RUN.
  - A rejected write leaves the register unchanged and pulses opWrErr the next cycle.
  - A write to a profile not yet reached takes effect when that profile enters SETUP.
- All-invalid profiles with ipLoop=1: the block cycles through SETUP indefinitely with opControl=00 until ipStop.
- Index compare is unsigned. ipLast=0 plays profile 0 only.
- Reset mid-run: immediate IDLE and outputs 0; profile contents return to reset values.

Test Plan:
- Reset then no stimulus -> opControl=00, opBusy=0, all outputs 0 for 100 cycles.
- Program p0={00,10,50,2}, p1={FE,20,80,4}; ipLast=1, dwell=5, loop=0, start pulse -> SETUP p0 with control 00 for 1 cycle, 5 cycles control=01 with 10/50/2, 1 SETUP cycle, 5 cycles control=11 with 20/80/4, opDone pulse, then IDLE; total 13 cycles after start.
- Same profiles with loop=1 and dwell=0 -> pattern 00,01,00,11 repeating; ipStop mid-RUN -> opControl=00 and opBusy=0 next cycle, no opDone.
- p1 mode=FD, ipLast=2 -> p1 gets one SETUP cycle and no RUN; sequence goes p0 RUN, p1 SETUP, p2 SETUP, p2 RUN.
- During p0 RUN, write p0 step -> opWrErr pulse, value unchanged. Write p1 start=99 -> accepted, and p1 runs with opStartFreq=99.
- ipnReset asserted mid-RUN, then ipStart and ipStop asserted together -> IDLE remains, all profile modes FD, opControl=00.
